// File: rtl/gpio_port_bank.sv
// gpio_port_bank: MSP430-style digital I/O port bank.
// PxIN/PxOUT/PxDIR/PxIES/PxIE/PxIFG registers on the memory bus.
// The pin inputs pass through a synchroniser, and each pin can raise an edge interrupt.
// Pads are split into in/out/oe so that tristating stays at the chip top.
// Optional feature macro: GPIO_IV_EN.
//   Defined: adds a priority interrupt vector at offset 0x0E. Reading it clears the reported flag.
//   Undefined: offset 0x0E reads 0.
`timescale 1ns/1ps

module gpio_port_bank #(
    parameter int          PORT_WIDTH  = 16,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] BASE_ADDR   = 16'h0200
) (
    input  logic                  SysClock,
    input  logic                  rst,
    input  logic [15:0]           mab,
    input  logic [15:0]           mdb_in,
    output logic [15:0]           mdb_out,
    input  logic                  mr,
    input  logic                  mw,
    input  logic                  bw,
    input  logic [PORT_WIDTH-1:0] pin_in,
    output logic [PORT_WIDTH-1:0] pin_out,
    output logic [PORT_WIDTH-1:0] pin_oe,
    output logic                  irq
);

    // Word offsets (mab[4:1]) of the implemented registers
    localparam logic [3:0] OFF_IN  = 4'h0;  // 0x00
    localparam logic [3:0] OFF_OUT = 4'h1;  // 0x02
    localparam logic [3:0] OFF_DIR = 4'h2;  // 0x04
    localparam logic [3:0] OFF_IV  = 4'h7;  // 0x0E
    localparam logic [3:0] OFF_IES = 4'hC;  // 0x18
    localparam logic [3:0] OFF_IE  = 4'hD;  // 0x1A
    localparam logic [3:0] OFF_IFG = 4'hE;  // 0x1C

    // Architectural registers
    logic [PORT_WIDTH-1:0] r_out;
    logic [PORT_WIDTH-1:0] r_dir;
    logic [PORT_WIDTH-1:0] r_ies;
    logic [PORT_WIDTH-1:0] r_ie;
    logic [PORT_WIDTH-1:0] r_ifg;

    // Input synchroniser: stage 0 samples the pads, and the last stage is PxIN
    logic [SYNC_STAGES-1:0][PORT_WIDTH-1:0] r_sync;
    // Previous-cycle PxIN, used for edge detection
    logic [PORT_WIDTH-1:0] r_hist;
    // Low for the first cycle after reset, so that the history loads without flagging
    logic                  r_armed;

    // Bus decode
    logic                  w_hit;
    logic [3:0]            w_off;
    logic                  w_wr;
    logic                  w_rd;
    logic [PORT_WIDTH-1:0] w_in;

    // Merged write values (byte lanes resolved) per writable register
    logic [15:0]           w_out_m;
    logic [15:0]           w_dir_m;
    logic [15:0]           w_ies_m;
    logic [15:0]           w_ie_m;
    logic [15:0]           w_ifg_m;

    // Interrupt flag logic
    logic [PORT_WIDTH-1:0] w_edge;
    logic [PORT_WIDTH-1:0] w_iv_clr;
    logic [PORT_WIDTH-1:0] w_ifg_next;
    logic [15:0]           w_iv_word;

    // Read path
    logic [15:0]           w_rdata;

    // Byte writes take their data from mdb_in[7:0] and place it in the lane selected by mab[0].
    // Word writes replace all bits.
    function automatic logic [15:0] f_merge(input logic [15:0] old_val,
                                            input logic [15:0] data,
                                            input logic        byte_acc,
                                            input logic        hi_byte);
        logic [15:0] res;
        res = data;
        if (byte_acc) begin
            if (hi_byte) begin
                res = {data[7:0], old_val[7:0]};
            end else begin
                res = {old_val[15:8], data[7:0]};
            end
        end
        return res;
    endfunction

    assign w_hit = (mab[15:5] == BASE_ADDR[15:5]);
    assign w_off = mab[4:1];
    assign w_wr  = mw & w_hit;
    assign w_rd  = mr & w_hit;
    assign w_in  = r_sync[SYNC_STAGES-1];

    assign w_out_m = f_merge(16'(r_out), mdb_in, bw, mab[0]);
    assign w_dir_m = f_merge(16'(r_dir), mdb_in, bw, mab[0]);
    assign w_ies_m = f_merge(16'(r_ies), mdb_in, bw, mab[0]);
    assign w_ie_m  = f_merge(16'(r_ie),  mdb_in, bw, mab[0]);
    assign w_ifg_m = f_merge(16'(r_ifg), mdb_in, bw, mab[0]);

    // Per-pin edge detector: IES=0 selects rising edges and IES=1 selects falling edges
    genvar gi;
    generate
        for (gi = 0; gi < PORT_WIDTH; gi++) begin : g_edge
            assign w_edge[gi] = r_armed & (r_ies[gi] ? (~w_in[gi] &  r_hist[gi])
                                                     : ( w_in[gi] & ~r_hist[gi]));
        end
    endgenerate

`ifdef GPIO_IV_EN
    logic                  w_iv_any;
    logic [3:0]            w_iv_idx;
    logic [PORT_WIDTH-1:0] w_iv_onehot;

    // Find the lowest pending flag. IE does not take part in the priority.
    always_comb begin
        w_iv_any = 1'b0;
        w_iv_idx = 4'd0;
        for (int i = PORT_WIDTH - 1; i >= 0; i--) begin
            if (r_ifg[i]) begin
                w_iv_any = 1'b1;
                w_iv_idx = 4'(i);
            end
        end
    end

    generate
        for (gi = 0; gi < PORT_WIDTH; gi++) begin : g_iv_sel
            assign w_iv_onehot[gi] = (w_iv_idx == 4'(gi));
        end
    endgenerate

    // The vector value is 2*(n+1) for the lowest pending pin n.
    assign w_iv_word = w_iv_any ? {10'd0, 5'(w_iv_idx) + 5'd1, 1'b0} : 16'd0;

    // A pure read of IV acknowledges the reported flag.
    // A read in the same cycle as a write has no side effect.
    assign w_iv_clr  = (w_rd && !mw && (w_off == OFF_IV) && w_iv_any) ? w_iv_onehot
                                                                      : '0;
`else
    assign w_iv_word = 16'd0;
    assign w_iv_clr  = '0;
`endif

    // Next flag value: a software write or an IV acknowledge comes first.
    // A fresh edge then overrides either of them.
    always_comb begin
        w_ifg_next = r_ifg & ~w_iv_clr;
        if (w_wr && (w_off == OFF_IFG)) begin
            w_ifg_next = w_ifg_m[PORT_WIDTH-1:0];
        end
        w_ifg_next = w_ifg_next | w_edge;
    end

    // Synchroniser chain, edge history and arm flag
    always_ff @(posedge SysClock) begin
        if (rst) begin
            r_sync  <= '0;
            r_hist  <= '0;
            r_armed <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1) begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
            end else begin
                r_sync[0] <= pin_in;
            end
            r_hist  <= w_in;
            r_armed <= 1'b1;
        end
    end

    // Software-visible configuration registers. Writes to IN and IV are ignored.
    always_ff @(posedge SysClock) begin
        if (rst) begin
            r_out <= '0;
            r_dir <= '0;
            r_ies <= '0;
            r_ie  <= '0;
        end else if (w_wr) begin
            case (w_off)
                OFF_OUT: r_out <= w_out_m[PORT_WIDTH-1:0];
                OFF_DIR: r_dir <= w_dir_m[PORT_WIDTH-1:0];
                OFF_IES: r_ies <= w_ies_m[PORT_WIDTH-1:0];
                OFF_IE:  r_ie  <= w_ie_m[PORT_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Interrupt flag register
    always_ff @(posedge SysClock) begin
        if (rst) begin
            r_ifg <= '0;
        end else begin
            r_ifg <= w_ifg_next;
        end
    end

    // Read mux. Unimplemented offsets and unused high bits read as zero.
    always_comb begin
        w_rdata = 16'd0;
        case (w_off)
            OFF_IN:  w_rdata = 16'(w_in);
            OFF_OUT: w_rdata = 16'(r_out);
            OFF_DIR: w_rdata = 16'(r_dir);
            OFF_IV:  w_rdata = w_iv_word;
            OFF_IES: w_rdata = 16'(r_ies);
            OFF_IE:  w_rdata = 16'(r_ie);
            OFF_IFG: w_rdata = 16'(r_ifg);
            default: w_rdata = 16'd0;
        endcase
    end

    // Drive the bus only during a selected read. A byte read returns its lane in [7:0].
    always_comb begin
        mdb_out = 16'd0;
        if (!rst && w_rd) begin
            if (bw) begin
                mdb_out = mab[0] ? {8'd0, w_rdata[15:8]} : {8'd0, w_rdata[7:0]};
            end else begin
                mdb_out = w_rdata;
            end
        end
    end

    assign pin_out = r_out;
    assign pin_oe  = r_dir;
    assign irq     = |(r_ifg & r_ie);

endmodule
